// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for the shared memory port
//
// Purpose: shares one memory port between three requesters (0 = instruction
// fetch, 1 = load/store FSM, 2 = debug/DMA). One transaction runs at a time,
// and a watchdog aborts any access whose MFC never arrives.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req/rw/addr/wdata   per-requester request, direction (1 = read), address,
//                       write data; requester i at [i*W +: W]
//   gnt, ack, err       one-hot grant, one-cycle one-hot ack, timeout flag
//   rdata               read data captured at MFC, held until next capture
//   mem_en/mem_rw/mem_addr/mem_wdata/mem_rdata/mem_mfc  memory-side port
module mem_port_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [2:0]          rw,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          ack,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_mfc
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Count value in the last ACCESS cycle allowed before the watchdog fires.
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        ack_q, ack_d;
  logic              err_q, err_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        last_q, last_d;

  logic [1:0]        pick;
  logic [2:0]        sel_gnt;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Round-robin: scan starting just after the last granted requester.
  always_comb begin
    pick = 2'd0;
    case (last_q)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    sel_gnt   = 3'b001;
    sel_rw    = rw[0];
    sel_addr  = addr[0*ADDR_W +: ADDR_W];
    sel_wdata = wdata[0*DATA_W +: DATA_W];
    case (pick)
      2'd1: begin
        sel_gnt   = 3'b010;
        sel_rw    = rw[1];
        sel_addr  = addr[1*ADDR_W +: ADDR_W];
        sel_wdata = wdata[1*DATA_W +: DATA_W];
      end
      2'd2: begin
        sel_gnt   = 3'b100;
        sel_rw    = rw[2];
        sel_addr  = addr[2*ADDR_W +: ADDR_W];
        sel_wdata = wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = ack_q;
    err_d       = err_q;
    mem_en_d    = mem_en_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = GRANT;
          gnt_d       = sel_gnt;
          last_d      = pick;
          mem_rw_d    = sel_rw;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
        end
      end
      GRANT: begin
        // One cycle of address/data setup before the enable rises.
        cnt_d    = '0;
        mem_en_d = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        // MFC takes priority over an expiring watchdog in the same cycle.
        if (mem_mfc) begin
          if (mem_rw_q) rdata_d = mem_rdata;
          state_d  = DONE;
          mem_en_d = 1'b0;
          ack_d    = gnt_q;
          err_d    = 1'b0;
        end else if (TIMEOUT != 0 && cnt_q == TMO_LAST) begin
          state_d  = DONE;
          mem_en_d = 1'b0;
          ack_d    = gnt_q;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ack_d   = 3'b000;
        err_d   = 1'b0;
        gnt_d   = 3'b000;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      last_q      <= 2'd2;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  rw;
  logic [17:0] addr;
  logic [47:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  ack;
  logic        err;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_rw;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_mfc;

  int total  = 0;
  int passed = 0;

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(16), .TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_mfc(mem_mfc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs one transaction from the current negedge until ack (bounded).
  // mfc_at = N raises MFC during the Nth ACCESS cycle (0 = never);
  // drop_at = N drops req during the Nth ACCESS cycle (0 = never).
  task automatic txn(input int mfc_at, input int drop_at,
                     output logic [2:0] g, output logic [2:0] a, output logic e,
                     output int en_cyc, output int idle_cyc,
                     output logic multi, output logic unstable);
    logic [5:0]  a0;
    logic [15:0] w0;
    logic        r0;
    g = 0; a = 0; e = 0; en_cyc = 0; idle_cyc = 0; multi = 0; unstable = 0;
    a0 = 0; w0 = 0; r0 = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (gnt != 3'b000 && !$onehot(gnt)) multi = 1;
      if (gnt == 3'b000 && g == 3'b000) idle_cyc++;
      if (gnt != 3'b000 && g == 3'b000) g = gnt;
      if (mem_en) begin
        en_cyc++;
        if (en_cyc == 1) begin
          a0 = mem_addr; w0 = mem_wdata; r0 = mem_rw;
        end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_rw !== r0) begin
          unstable = 1;
        end
      end
      mem_mfc = (mem_en && mfc_at != 0 && en_cyc == mfc_at);
      if (mem_en && drop_at != 0 && en_cyc == drop_at) req = 3'b000;
      if (ack != 3'b000) begin
        a = ack; e = err; mem_mfc = 1'b0;
        break;
      end
    end
  endtask

  logic [2:0] g, a;
  logic       e, multi, unstable;
  int         en_cyc, idle_cyc, cnt;
  logic [2:0] exp_order [4];

  initial begin
    exp_order[0] = 3'b010; exp_order[1] = 3'b100;
    exp_order[2] = 3'b001; exp_order[3] = 3'b010;
    rst = 1'b1; req = 0; rw = 0; addr = 0; wdata = 0; mem_rdata = 0; mem_mfc = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_gnt", gnt, 3'b000);
    chk("reset_ack", ack, 3'b000);
    chk("reset_err", err, 1'b0);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_mem_addr", mem_addr, 6'h00);
    chk("reset_rdata", rdata, 16'h0000);
    rst = 1'b0;

    // Single read from requester 0, MFC in the 2nd ACCESS cycle.
    req = 3'b001; rw = 3'b001; addr[5:0] = 6'h05; mem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("rd_grant_gnt", gnt, 3'b001);
    chk("rd_grant_addr", mem_addr, 6'h05);
    chk("rd_grant_rw", mem_rw, 1'b1);
    chk("rd_grant_en", mem_en, 1'b0);
    @(negedge clk);
    chk("rd_access1_en", mem_en, 1'b1);
    @(negedge clk);
    chk("rd_access2_en", mem_en, 1'b1);
    mem_mfc = 1'b1;
    @(negedge clk);
    mem_mfc = 1'b0; req = 3'b000;
    chk("rd_done_ack", ack, 3'b001);
    chk("rd_done_err", err, 1'b0);
    chk("rd_done_rdata", rdata, 16'hBEEF);
    chk("rd_done_en", mem_en, 1'b0);
    chk("rd_done_gnt", gnt, 3'b001);
    @(negedge clk);
    chk("rd_idle_ack", ack, 3'b000);
    chk("rd_idle_gnt", gnt, 3'b000);

    // Round-robin with all three requesting; last grant was 0.
    req = 3'b111; rw = 3'b111;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 16'h1000 + 16'(i);
      txn(1, 0, g, a, e, en_cyc, idle_cyc, multi, unstable);
      chk($sformatf("rr%0d_gnt", i), g, exp_order[i]);
      chk($sformatf("rr%0d_ack", i), a, exp_order[i]);
      chk($sformatf("rr%0d_multi", i), multi, 1'b0);
      chk($sformatf("rr%0d_en", i), en_cyc, 1);
      if (i > 0) chk($sformatf("rr%0d_idle", i), idle_cyc, 1);
    end
    chk("rr_rdata", rdata, 16'h1003);

    // Write from requester 1; rdata must keep its previous value.
    req = 3'b010; rw = 3'b000; addr[11:6] = 6'h3F; wdata[31:16] = 16'h1234;
    mem_rdata = 16'hDEAD;
    txn(2, 0, g, a, e, en_cyc, idle_cyc, multi, unstable);
    chk("wr_ack", a, 3'b010);
    chk("wr_err", e, 1'b0);
    chk("wr_mem_rw", mem_rw, 1'b0);
    chk("wr_mem_wdata", mem_wdata, 16'h1234);
    chk("wr_mem_addr", mem_addr, 6'h3F);
    chk("wr_stable", unstable, 1'b0);
    chk("wr_rdata", rdata, 16'h1003);

    // Watchdog: no MFC at all.
    req = 3'b100; rw = 3'b100; addr[17:12] = 6'h2A; mem_rdata = 16'h5555;
    txn(0, 0, g, a, e, en_cyc, idle_cyc, multi, unstable);
    chk("wd_ack", a, 3'b100);
    chk("wd_err", e, 1'b1);
    chk("wd_en_cycles", en_cyc, 15);
    chk("wd_rdata", rdata, 16'h1003);
    @(negedge clk);
    chk("wd_idle_err", err, 1'b0);
    chk("wd_idle_gnt", gnt, 3'b000);

    // MFC in the 15th ACCESS cycle wins over the expiring watchdog.
    mem_rdata = 16'hA5A5;
    txn(15, 0, g, a, e, en_cyc, idle_cyc, multi, unstable);
    chk("wd15_ack", a, 3'b100);
    chk("wd15_err", e, 1'b0);
    chk("wd15_en_cycles", en_cyc, 15);
    chk("wd15_rdata", rdata, 16'hA5A5);

    // Requester 2 drops req in ACCESS; transaction still completes.
    req = 3'b100; mem_rdata = 16'h0F0F;
    txn(3, 1, g, a, e, en_cyc, idle_cyc, multi, unstable);
    chk("drop_ack", a, 3'b100);
    chk("drop_err", e, 1'b0);
    chk("drop_rdata", rdata, 16'h0F0F);
    @(negedge clk);
    chk("drop_ack_once", ack, 3'b000);
    @(negedge clk);
    chk("drop_no_regrant", gnt, 3'b000);

    // Reset during the 3rd ACCESS cycle.
    req = 3'b001; rw = 3'b001;
    cnt = 0;
    for (int c = 0; c < 10 && cnt < 3; c++) begin
      @(negedge clk);
      if (mem_en) cnt++;
    end
    chk("rst_reach_access3", cnt, 3);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_en", mem_en, 1'b0);
    chk("rst_async_gnt", gnt, 3'b000);
    @(negedge clk);
    chk("rst_no_ack", ack, 3'b000);
    rst = 1'b0;
    req = 3'b011; rw = 3'b011; mem_rdata = 16'h7777;
    txn(1, 0, g, a, e, en_cyc, idle_cyc, multi, unstable);
    chk("post_rst_gnt", g, 3'b001);
    chk("post_rst_ack", a, 3'b001);
    chk("post_rst_rdata", rdata, 16'h7777);
    req = 3'b000;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (address, write data, read data, mem enable, R/W, MFC) between three requesters: requester 0 is instruction fetch, requester 1 is the load/store FSM, requester 2 is the debug/DMA port.
- Grants are round-robin, and one transaction completes before the next begins.
- A watchdog aborts any access whose MFC never arrives.
- Sits between the requester FSMs and the MAR/MDR/memory datapath.

Parameters:
- ADDR_W, 6, address width.
- DATA_W, 16, data width.
- TIMEOUT, 15, maximum ACCESS cycles waiting for MFC. 0 disables the watchdog.
- CNT_W, 4, watchdog counter width. Must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  3  per-requester request; held high until ack
- rw  in  3  per-requester direction; 1 = read (load), 0 = write (store)
- addr  in  3*ADDR_W  per-requester address; requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  per-requester write data, same packing
- gnt  out  3  one-hot grant, high GRANT through DONE
- ack  out  3  one-hot, one-cycle completion pulse
- err  out  1  high with ack when the transaction timed out
- rdata  out  DATA_W  read data captured at MFC; valid with ack, held until next capture
- mem_en  out  1  memory enable
- mem_rw  out  1  memory direction (1 = read)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_mfc  in  1  memory function complete

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; gnt, ack, err, mem_en, mem_rw = 0; mem_addr, mem_wdata, rdata = 0; watchdog count = 0; last-granted pointer = 2, so requester 0 wins first.
- States are IDLE, GRANT, ACCESS, DONE.
- IDLE:
  - If req is nonzero, pick the first asserted requester scanning from (last+1) mod 3 upward.
  - Latch its rw, addr and wdata into mem_rw, mem_addr and mem_wdata.
  - Set gnt[i], set last = i, and go to GRANT.
  - If req is zero, stay in IDLE.
- GRANT: lasts one cycle with mem_en = 0, giving the address and data one cycle of setup. Clear the count and go to ACCESS.
- ACCESS:
  - mem_en = 1; address, data and direction are held stable.
  - If mem_mfc = 1: capture rdata <= mem_rdata on reads (rdata is unchanged on writes), then go to DONE with err = 0.
  - Else if TIMEOUT != 0 and count == TIMEOUT-1: go to DONE with err = 1, and leave rdata unchanged.
  - Else increment count.
  - If MFC arrives in the same cycle the count expires, MFC wins and err = 0.
- DONE: mem_en = 0; ack[i] = 1 for exactly one cycle; err is valid this cycle; gnt[i] is still high. Go to IDLE; gnt and err clear on entry to IDLE.
- Latency: with req sampled at edge k and MFC first high during the cycle after edge k+2, ack is high in the cycle after edge k+3. Minimum request-to-ack is 4 cycles.
- Back-to-back transactions: IDLE lasts at least one cycle between transactions (no bus turnaround overlap).
  - A requester that keeps req high after ack is re-arbitrated behind any other pending requester.
- req deasserted mid-transaction (GRANT or ACCESS): no abort; the transaction completes and ack still pulses.
- Requests arriving in GRANT, ACCESS or DONE are not sampled until IDLE.
- mem_mfc is ignored outside ACCESS.
- rst mid-operation: immediate return to the reset values. mem_en drops asynchronously, the transaction is lost, and no ack is issued.

Test Plan:
- Single read: req = 001, rw[0] = 1, addr0 = 6'h05, memory returns 16'hBEEF with MFC 2 cycles into ACCESS -> mem_addr = 05 and mem_rw = 1 from GRANT, mem_en high 2 cycles, ack = 001 for one cycle with rdata = BEEF and err = 0.
- Round-robin: req = 111 held continuously (re-raised after each ack), MFC after 1 cycle -> grant order 0, 1, 2, 0; gnt is never multi-hot; IDLE lasts one cycle between each transaction.
- Write: requester 1, rw = 0, addr = 6'h3F, wdata = 16'h1234 -> mem_rw = 0, mem_wdata = 1234 held throughout ACCESS; ack = 010; rdata keeps its previous value.
- Watchdog: TIMEOUT = 15, MFC never asserted -> mem_en high exactly 15 cycles, then ack and err = 1, then IDLE. A variant raises MFC in the 15th ACCESS cycle -> err = 0 and rdata is captured.
- Reset mid-ACCESS: assert rst during cycle 3 of ACCESS -> mem_en and gnt go to 0 without a clock edge, and no ack is issued. After release, with req = 011, requester 0 is granted first.
- Requester drop: requester 2 deasserts req during ACCESS -> the transaction still completes and ack = 100 pulses once.
